// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM demodulator recovering the duty code from high time per period
module pwm_capture #(
    parameter int WIDTH   = 8,
    parameter int PERIOD  = 256,
    parameter int TIMEOUT = 512
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty_out,
    output logic             duty_valid,
    output logic             period_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] PERIOD_C   = CW'(PERIOD);
    localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CODE_MAX   = CW'((2 ** WIDTH) - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STUCK   = 2'd2;

    logic             sync1;
    logic             sync2;
    logic             s;
    logic             rise_det;
    logic [CW-1:0]    period_cnt;
    logic [CW-1:0]    high_cnt;
    logic [1:0]       state;
    logic             timeout_hit;
    logic [WIDTH-1:0] high_code;
    logic [WIDTH-1:0] stuck_code;

    // The counter is about to reach TIMEOUT this cycle; a coincident edge takes priority.
    assign timeout_hit = (period_cnt == TIMEOUT_M1) && !rise_det;
    assign high_code   = (high_cnt > CODE_MAX) ? {WIDTH{1'b1}} : high_cnt[WIDTH-1:0];
    assign stuck_code  = s ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    // Two-flop synchronizer, then a registered level and rising-edge strobe.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            s        <= 1'b0;
            rise_det <= 1'b0;
        end else begin
            sync1    <= pwm_in;
            sync2    <= sync1;
            s        <= sync2;
            rise_det <= sync2 & ~s;
        end
    end

    // Period and high-time counters: reload on an edge, otherwise count and saturate.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise_det) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
        end else begin
            if (timeout_hit) begin
                period_cnt <= '0;
            end else if (period_cnt != TIMEOUT_C) begin
                period_cnt <= period_cnt + CNT_ONE;
            end
            if (s && (high_cnt != TIMEOUT_C)) begin
                high_cnt <= high_cnt + CNT_ONE;
            end
        end
    end

    // Measurement state machine and registered outputs; compares use pre-reload counts.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state      <= ST_IDLE;
            duty_out   <= '0;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_STUCK: begin
                    if (rise_det) begin
                        state <= ST_MEASURE;
                    end else if (timeout_hit) begin
                        state      <= ST_STUCK;
                        duty_out   <= stuck_code;
                        duty_valid <= 1'b1;
                        period_err <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (rise_det) begin
                        if (period_cnt == PERIOD_C) begin
                            duty_out   <= high_code;
                            duty_valid <= 1'b1;
                            period_err <= 1'b0;
                        end else begin
                            period_err <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state      <= ST_STUCK;
                        duty_out   <= stuck_code;
                        duty_valid <= 1'b1;
                        period_err <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
